cmd_arbiter: RTL and testbench

- Sits between the UART command path (RemoteComm receiver), the tour-move generator and cmd_proc.
- Owns cmd_proc and grants it to one requester at a time: remote or tour.
- Tracks the one outstanding command and generates the single response byte to the UART transmitter for each accepted command.
- Intercepts TOUR commands, launches the tour generator, and guards against a hung cmd_proc with a watchdog.

---
 rtl/cmd_arb_pkg.sv | 26 ++
 rtl/arb_watchdog.sv | 34 +++
 rtl/cmd_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_cmd_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for cmd_arbiter.
package cmd_arb_pkg;

  typedef enum logic [3:0] {
    OpCal         = 4'h2,
    OpMove        = 4'h4,
    OpMoveFanfare = 4'h5,
    OpTour        = 4'h6,
    OpAbort       = 4'hF
  } opcode_e;

  localparam logic [7:0] RespAckPos  = 8'hA5;
  localparam logic [7:0] RespDone    = 8'h5A;
  localparam logic [7:0] RespTimeout = 8'hEE;
  localparam logic [7:0] RespBusyNak = 8'hE1;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFwd      = 3'd1,
    StWaitResp = 3'd2,
    StTourIdle = 3'd3,
    StTourFwd  = 3'd4,
    StTourWait = 3'd5
  } state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating watchdog counter: counts while enabled, expires when it reaches Limit.
module arb_watchdog #(
  parameter int unsigned      Width = 24,
  parameter logic [Width-1:0] Limit = '1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == Limit);

endmodule

// File: rtl/cmd_arbiter.sv
// Grants cmd_proc to the remote or tour requester, sends one response byte per command.
// Optional tour abort (opcode 4'hF) is enabled by defining CMD_ARB_ABORT_EN.
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W    = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CLKS = {TIMEOUT_W{1'b1}}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rmt_cmd,
  input  logic        rmt_cmd_rdy,
  output logic        rmt_clr_cmd_rdy,
  input  logic [15:0] tc_cmd,
  input  logic        tc_cmd_rdy,
  input  logic        tc_last,
  output logic        tc_clr_cmd_rdy,
  output logic        tour_go,
  output logic [2:0]  tour_x,
  output logic [2:0]  tour_y,
  output logic [15:0] cp_cmd,
  output logic        cp_cmd_rdy,
  input  logic        cp_clr_cmd_rdy,
  input  logic        cp_send_resp,
  output logic [7:0]  resp,
  output logic        send_resp,
  output logic        tour_active
);

  localparam logic [TIMEOUT_W-1:0] WdLimit = TIMEOUT_CLKS - TIMEOUT_W'(1);

  state_e      state_d, state_q;
  logic [15:0] cp_cmd_d, cp_cmd_q;
  logic        cp_cmd_rdy_d, cp_cmd_rdy_q;
  logic        rmt_clr_d, rmt_clr_q;
  logic        tc_clr_d, tc_clr_q;
  logic        tour_go_d, tour_go_q;
  logic [2:0]  tour_x_d, tour_x_q, tour_y_d, tour_y_q;
  logic        tour_active_d, tour_active_q;
  logic        last_d, last_q;
  logic        abort_d, abort_q;
  logic        nak_pend_d, nak_pend_q;
  logic [7:0]  resp_d, resp_q;
  logic        send_resp_d, send_resp_q;

  logic        fsm_vld;
  logic [7:0]  fsm_resp;
  logic        wd_en, wd_clr, wd_expire;
  opcode_e     rmt_op;
  logic        rmt_vld, tc_vld, rmt_abort, nak_req;

  // A ready still high while our clear pulse is out has already been consumed.
  assign rmt_vld = rmt_cmd_rdy && !rmt_clr_q;
  assign tc_vld  = tc_cmd_rdy && !tc_clr_q;
  assign rmt_op  = opcode_e'(rmt_cmd[15:12]);

`ifdef CMD_ARB_ABORT_EN
  assign rmt_abort = rmt_vld && tour_active_q && (rmt_op == OpAbort);
`else
  assign rmt_abort = 1'b0;
`endif

  assign nak_req = rmt_vld && tour_active_q && !rmt_abort;

  assign wd_en  = (state_q == StFwd) || (state_q == StWaitResp) ||
                  (state_q == StTourFwd) || (state_q == StTourWait);
  assign wd_clr = (state_d != state_q);

  arb_watchdog #(
    .Width (TIMEOUT_W),
    .Limit (WdLimit)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    cp_cmd_d      = cp_cmd_q;
    cp_cmd_rdy_d  = cp_cmd_rdy_q;
    rmt_clr_d     = 1'b0;
    tc_clr_d      = 1'b0;
    tour_go_d     = 1'b0;
    tour_x_d      = tour_x_q;
    tour_y_d      = tour_y_q;
    tour_active_d = tour_active_q;
    last_d        = last_q;
    abort_d       = abort_q;
    fsm_vld       = 1'b0;
    fsm_resp      = RespDone;

    if (wd_expire) begin
      fsm_vld       = 1'b1;
      fsm_resp      = RespTimeout;
      cp_cmd_rdy_d  = 1'b0;
      tour_active_d = 1'b0;
      state_d       = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rmt_vld) begin
            rmt_clr_d = 1'b1;
            if (rmt_op == OpTour) begin
              tour_go_d     = 1'b1;
              tour_x_d      = rmt_cmd[6:4];
              tour_y_d      = rmt_cmd[2:0];
              tour_active_d = 1'b1;
              state_d       = StTourIdle;
            end else begin
              cp_cmd_d     = rmt_cmd;
              cp_cmd_rdy_d = 1'b1;
              state_d      = StFwd;
            end
          end
        end
        StFwd: begin
          if (cp_clr_cmd_rdy) begin
            cp_cmd_rdy_d = 1'b0;
            state_d      = StWaitResp;
          end
        end
        StWaitResp: begin
          if (cp_send_resp) begin
            fsm_vld = 1'b1;
            state_d = StIdle;
          end
        end
        StTourIdle: begin
          if (rmt_abort) begin
            fsm_vld       = 1'b1;
            tour_active_d = 1'b0;
            state_d       = StIdle;
          end else if (tc_vld) begin
            cp_cmd_d     = tc_cmd;
            cp_cmd_rdy_d = 1'b1;
            tc_clr_d     = 1'b1;
            last_d       = tc_last;
            state_d      = StTourFwd;
          end
        end
        StTourFwd: begin
          if (cp_clr_cmd_rdy) begin
            cp_cmd_rdy_d = 1'b0;
            state_d      = StTourWait;
          end
        end
        StTourWait: begin
          if (cp_send_resp) begin
            fsm_vld = 1'b1;
            if (last_q || abort_q || rmt_abort) begin
              tour_active_d = 1'b0;
              state_d       = StIdle;
            end else begin
              fsm_resp = RespAckPos;
              state_d  = StTourIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (nak_req || rmt_abort) rmt_clr_d = 1'b1;
    if (rmt_abort && tc_vld) tc_clr_d = 1'b1;
    // Abort mid-command: let cmd_proc finish, then end the tour on its response.
    if (rmt_abort && (state_d != StIdle)) abort_d = 1'b1;
    if (state_d == StIdle) abort_d = 1'b0;

    // FSM responses win the single response slot; one NAK may wait a cycle.
    resp_d      = resp_q;
    send_resp_d = 1'b0;
    nak_pend_d  = 1'b0;
    if (fsm_vld) begin
      resp_d      = fsm_resp;
      send_resp_d = 1'b1;
      nak_pend_d  = nak_pend_q || nak_req;
    end else if (nak_pend_q || nak_req) begin
      resp_d      = RespBusyNak;
      send_resp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cp_cmd_q      <= '0;
      cp_cmd_rdy_q  <= 1'b0;
      rmt_clr_q     <= 1'b0;
      tc_clr_q      <= 1'b0;
      tour_go_q     <= 1'b0;
      tour_x_q      <= '0;
      tour_y_q      <= '0;
      tour_active_q <= 1'b0;
      last_q        <= 1'b0;
      abort_q       <= 1'b0;
      nak_pend_q    <= 1'b0;
      resp_q        <= '0;
      send_resp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cp_cmd_q      <= cp_cmd_d;
      cp_cmd_rdy_q  <= cp_cmd_rdy_d;
      rmt_clr_q     <= rmt_clr_d;
      tc_clr_q      <= tc_clr_d;
      tour_go_q     <= tour_go_d;
      tour_x_q      <= tour_x_d;
      tour_y_q      <= tour_y_d;
      tour_active_q <= tour_active_d;
      last_q        <= last_d;
      abort_q       <= abort_d;
      nak_pend_q    <= nak_pend_d;
      resp_q        <= resp_d;
      send_resp_q   <= send_resp_d;
    end
  end

  assign rmt_clr_cmd_rdy = rmt_clr_q;
  assign tc_clr_cmd_rdy  = tc_clr_q;
  assign tour_go         = tour_go_q;
  assign tour_x          = tour_x_q;
  assign tour_y          = tour_y_q;
  assign cp_cmd          = cp_cmd_q;
  assign cp_cmd_rdy      = cp_cmd_rdy_q;
  assign resp            = resp_q;
  assign send_resp       = send_resp_q;
  assign tour_active     = tour_active_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Randomized bench for cmd_arbiter: expected response/forward streams built from command-level rules.
module tb_cmd_arbiter;

  localparam int unsigned ToClks = 100;
  localparam logic [7:0]  RAck   = 8'hA5;
  localparam logic [7:0]  RDone  = 8'h5A;
  localparam logic [7:0]  RTmo   = 8'hEE;
  localparam logic [7:0]  RNak   = 8'hE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rmt_cmd = '0;
  logic        rmt_cmd_rdy = 1'b0;
  logic        rmt_clr_cmd_rdy;
  logic [15:0] tc_cmd = '0;
  logic        tc_cmd_rdy = 1'b0;
  logic        tc_last = 1'b0;
  logic        tc_clr_cmd_rdy;
  logic        tour_go;
  logic [2:0]  tour_x, tour_y;
  logic [15:0] cp_cmd;
  logic        cp_cmd_rdy;
  logic        cp_clr_cmd_rdy = 1'b0;
  logic        cp_send_resp = 1'b0;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tour_active;

  cmd_arbiter #(
    .TIMEOUT_W    (24),
    .TIMEOUT_CLKS (24'd100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rmt_cmd         (rmt_cmd),
    .rmt_cmd_rdy     (rmt_cmd_rdy),
    .rmt_clr_cmd_rdy (rmt_clr_cmd_rdy),
    .tc_cmd          (tc_cmd),
    .tc_cmd_rdy      (tc_cmd_rdy),
    .tc_last         (tc_last),
    .tc_clr_cmd_rdy  (tc_clr_cmd_rdy),
    .tour_go         (tour_go),
    .tour_x          (tour_x),
    .tour_y          (tour_y),
    .cp_cmd          (cp_cmd),
    .cp_cmd_rdy      (cp_cmd_rdy),
    .cp_clr_cmd_rdy  (cp_clr_cmd_rdy),
    .cp_send_resp    (cp_send_resp),
    .resp            (resp),
    .send_resp       (send_resp),
    .tour_active     (tour_active)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got_q[$];
  int unsigned got_t_q[$];
  logic [15:0] fwd_q[$];
  logic [7:0]  exp_r[$];
  logic [15:0] exp_f[$];
  int unsigned go_cnt = 0;
  int unsigned tc_clr_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          cp_auto = 1'b0;

  always @(negedge clk) begin
    if (send_resp) begin
      got_q.push_back(resp);
      got_t_q.push_back(cyc);
    end
    if (tour_go) go_cnt <= go_cnt + 1;
    if (tc_clr_cmd_rdy) tc_clr_cnt <= tc_clr_cnt + 1;
  end

  // cmd_proc stand-in: random consume and completion delays
  initial begin
    forever begin
      @(negedge clk);
      if (cp_auto && rst_n && cp_cmd_rdy) begin
        fwd_q.push_back(cp_cmd);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        cp_clr_cmd_rdy = 1'b1;
        @(negedge clk);
        cp_clr_cmd_rdy = 1'b0;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        cp_send_resp = 1'b1;
        @(negedge clk);
        cp_send_resp = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench hung");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] outs_vec();
    return {28'd0, rmt_clr_cmd_rdy, tc_clr_cmd_rdy, tour_go, tour_x, tour_y, cp_cmd,
            cp_cmd_rdy, resp, send_resp, tour_active};
  endfunction

  task automatic start_scn();
    got_q.delete();
    got_t_q.delete();
    fwd_q.delete();
    exp_r.delete();
    exp_f.delete();
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nresp"}, got_q.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < got_q.size(); i++)
      check($sformatf("%s_resp%0d", tag, i), got_q[i], exp_r[i]);
    check({tag, "_nfwd"}, fwd_q.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < fwd_q.size(); i++)
      check($sformatf("%s_fwd%0d", tag, i), fwd_q[i], exp_f[i]);
  endtask

  task automatic send_rmt(input logic [15:0] c);
    int n = 0;
    @(negedge clk);
    rmt_cmd     = c;
    rmt_cmd_rdy = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rmt_clr_cmd_rdy && n < 300);
    if (!rmt_clr_cmd_rdy) check("rmt_clr_wait", 0, 1);
    rmt_cmd_rdy = 1'b0;
  endtask

  task automatic send_tc(input logic [15:0] c, input logic last);
    int n = 0;
    @(negedge clk);
    tc_cmd     = c;
    tc_last    = last;
    tc_cmd_rdy = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!tc_clr_cmd_rdy && n < 300);
    if (!tc_clr_cmd_rdy) check("tc_clr_wait", 0, 1);
    tc_cmd_rdy = 1'b0;
  endtask

  task automatic wait_resp(input int unsigned k);
    int n = 0;
    while (got_q.size() < k && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < k) check("resp_wait", got_q.size(), k);
  endtask

  task automatic cp_ack();
    int n = 0;
    while (!cp_cmd_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cp_cmd_rdy) check("cp_rdy_wait", 0, 1);
    fwd_q.push_back(cp_cmd);
    cp_clr_cmd_rdy = 1'b1;
    @(negedge clk);
    cp_clr_cmd_rdy = 1'b0;
  endtask

  task automatic cp_done();
    cp_send_resp = 1'b1;
    @(negedge clk);
    cp_send_resp = 1'b0;
  endtask

  task automatic do_remote(input logic [15:0] c);
    start_scn();
    exp_f.push_back(c);
    exp_r.push_back(RDone);
    send_rmt(c);
    check("fwd_rdy_latency", cp_cmd_rdy, 1);
    check("fwd_cmd", cp_cmd, c);
    wait_resp(1);
    settle();
    compare_all("remote");
  endtask

  task automatic start_tour(input logic [15:0] c);
    int unsigned g0 = go_cnt;
    send_rmt(c);
    @(negedge clk);
    check("tour_go_pulses", go_cnt - g0, 1);
    check("tour_x", tour_x, c[6:4]);
    check("tour_y", tour_y, c[2:0]);
    check("tour_active_set", tour_active, 1);
  endtask

  task automatic do_tour(input int unsigned n, input int unsigned nak_at);
    logic [15:0] c, m;
    int unsigned k = 0;
    logic last;
    c = {4'h6, 12'($urandom)};
    start_scn();
    start_tour(c);
    for (int i = 0; i < int'(n); i++) begin
      last = (i == int'(n) - 1);
      m = {($urandom_range(0, 1) != 0) ? 4'h4 : 4'h5, 12'($urandom)};
      exp_f.push_back(m);
      exp_r.push_back(last ? RDone : RAck);
      send_tc(m, last);
      k++;
      wait_resp(k);
      if (i == int'(nak_at) && !last) begin
        exp_r.push_back(RNak);
        send_rmt({4'h4, 12'($urandom)});
        k++;
        wait_resp(k);
      end
    end
    settle();
    check("tour_active_end", tour_active, 0);
    compare_all("tour");
  endtask

  task automatic do_timeout(input logic [15:0] c);
    int unsigned t0;
    cp_auto = 1'b0;
    start_scn();
    exp_r.push_back(RTmo);
    send_rmt(c);
    t0 = cyc;
    wait_resp(1);
    if (got_t_q.size() > 0) check("tmo_cycles", got_t_q[0] - t0, ToClks);
    check("tmo_cp_rdy", cp_cmd_rdy, 0);
    check("tmo_tour_active", tour_active, 0);
    settle();
    compare_all("timeout");
    cp_auto = 1'b1;
  endtask

  initial begin
    logic [15:0] m1, m2;
    int unsigned c0;
    int unsigned kind, n;
    logic [3:0] op;

    repeat (3) @(negedge clk);
    check("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", outs_vec(), 0);
    cp_auto = 1'b1;

    do_remote(16'h2000);
    do_tour(3, 3);
    do_tour(3, 0);

    // Both requesters ready in IDLE: only the remote one is served
    tc_cmd     = 16'h4777;
    tc_cmd_rdy = 1'b1;
    c0         = tc_clr_cnt;
    do_remote(16'h5123);
    check("both_rdy_tc_clr", tc_clr_cnt - c0, 0);
    tc_cmd_rdy = 1'b0;

    // NAK decided in the same cycle as a tour response
    cp_auto = 1'b0;
    start_scn();
    start_tour(16'h6023);
    m1 = 16'h4123;
    m2 = 16'h5321;
    send_tc(m1, 1'b0);
    cp_ack();
    rmt_cmd      = 16'h4004;
    rmt_cmd_rdy  = 1'b1;
    cp_send_resp = 1'b1;
    @(negedge clk);
    cp_send_resp = 1'b0;
    check("coinc_rmt_clr", rmt_clr_cmd_rdy, 1);
    rmt_cmd_rdy = 1'b0;
    wait_resp(2);
    if (got_t_q.size() >= 2) check("coinc_gap", got_t_q[1] - got_t_q[0], 1);
    send_tc(m2, 1'b1);
    cp_ack();
    cp_done();
    wait_resp(3);
    settle();
    exp_f = '{m1, m2};
    exp_r = '{RAck, RNak, RDone};
    compare_all("coinc");
    cp_auto = 1'b1;

    do_timeout(16'h4004);

    // Opcode F while the tour waits on cmd_proc
    cp_auto = 1'b0;
    start_scn();
    start_tour(16'h6155);
    send_tc(m1, 1'b0);
    cp_ack();
    send_rmt(16'hF000);
`ifdef CMD_ARB_ABORT_EN
    exp_f = '{m1};
    exp_r = '{RDone};
    cp_done();
    wait_resp(1);
    settle();
    check("abort_tour_active", tour_active, 0);
`else
    exp_f = '{m1, m2};
    exp_r = '{RNak, RAck, RDone};
    wait_resp(1);
    cp_done();
    wait_resp(2);
    check("f_nak_tour_active", tour_active, 1);
    send_tc(m2, 1'b1);
    cp_ack();
    cp_done();
    wait_resp(3);
    settle();
    check("f_nak_tour_end", tour_active, 0);
`endif
    compare_all("abort");

    // Asynchronous reset in TOUR_WAIT
    start_scn();
    start_tour(16'h6023);
    send_tc(m1, 1'b0);
    cp_ack();
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", outs_vec(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_outs", outs_vec(), 0);
    check("post_rst_nresp", got_q.size(), 0);
    cp_auto = 1'b1;
    do_remote(16'h4abc);

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        op = 4'($urandom);
        if (op == 4'h6) op = 4'h4;
        do_remote({op, 12'($urandom)});
      end else if (kind == 1) begin
        n = $urandom_range(1, 4);
        do_tour(n, $urandom_range(0, n));
      end else begin
        do_timeout({4'h5, 12'($urandom)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
